monitoreo_multicanal: RTL and testbench
=======================================

// Module: monitoreo_multicanal
// PURPOSE
//  N-channel temperature monitor; successor to the single-channel monitor.
//  Per channel: classifies signed samples as cold/normal/hot, enforces persistence before alarming, drives heater/fan.
//  Adds sample-valid qualification, per-channel parametrised thresholds, a global alert and an optional hysteresis band.
//  Sits between the sensor sampling front-end and the actuator/alarm logic.
// PARAMETERS
//  N_CANALES  4     number of independent channels (>=1)
//  W_TEMP     11    signed sample width, tenths of a degree
//  T_BAJO     180   cold threshold: sample < T_BAJO is cold
//  T_ALTO     259   hot threshold: sample > T_ALTO is hot (T_ALTO > T_BAJO)
//  PERSIST    6     consecutive valid cold/hot samples required to alarm (>=1)
//  HIST       10    hysteresis margin; used only with MON_HISTERESIS_EN
// PORTS
//  clk            in   1             clock, all logic on rising edge
//  arst_n         in   1             synchronous active-low reset
//  temp_valido    in   1             temp_entrada holds a new sample for every channel this cycle
//  temp_entrada   in   N*W_TEMP      packed signed samples; channel i at [i*W_TEMP +: W_TEMP]
//  estado_actual  out  2*N           per-channel state: 00 NORMAL, 01 FRIO, 10 CALOR
//  alerta         out  N             channel i in FRIO or CALOR
//  calefactor     out  N             channel i in FRIO
//  ventilador     out  N             channel i in CALOR
//  alerta_global  out  1             OR of alerta
//  canal_alerta   out  clog2(N)      lowest-index alarming channel; 0 when none
// BEHAVIOUR
//  - Reset: arst_n low at a rising edge forces every state to NORMAL, all counters and outputs to 0; also mid-alarm.
//  - All outputs are registered and decoded from state. Latency: a sample accepted at edge k is reflected at edge k.
//  - temp_valido=0: state and counters hold; gaps do not break persistence.
//  - Counters cont_bajo/cont_alto per channel, width clog2(PERSIST+1), saturating, updated only on valid.
//  - NORMAL: cold sample -> cont_bajo+1, cont_alto=0; hot -> cont_alto+1, cont_bajo=0; in-band -> both 0.
//    Enter FRIO when the PERSIST-th consecutive cold sample is accepted (outputs high the same edge); CALOR likewise.
//  - FRIO: in-band sample -> NORMAL; hot sample -> CALOR directly (no persistence); cold -> stay. Counters cleared on exit.
//  - CALOR: in-band -> NORMAL; cold -> FRIO directly; hot -> stay.
//  - Compare signed at W_TEMP; T_BAJO and T_ALTO are exact boundaries (180 and 259 are in-band).
//  - Invariants: calefactor & ventilador never both set; alerta == calefactor | ventilador; estado 11 unreachable.
//  - Channels fully independent; canal_alerta is a combinational priority encoder over the registered alerta.
// CONFIGURATION
//  - MON_HISTERESIS_EN defined: leaving FRIO to NORMAL requires sample >= T_BAJO+HIST.
//    Leaving CALOR to NORMAL requires sample <= T_ALTO-HIST; samples between threshold and margin hold the alarm.
//    Require T_BAJO+HIST <= T_ALTO-HIST.
//  - Undefined: exit on the first in-band sample as above. HIST is ignored.
// STRUCTURE
//  - monitoreo_pkg: estado_t enum {NORMAL=2'b00, FRIO=2'b01, CALOR=2'b10}; classification enum {BAJO, RANGO, ALTO}.
//  - Sub-module monitoreo_canal: per-channel FSM, counters and decode, same parameters.
//    It is instantiated N_CANALES times by a generate loop.
//  - The top holds only the generate loop, the alerta_global OR and the canal_alerta encoder.
// TESTING
//  1. ch0=150 for 6 valid cycles -> alerta[0]=calefactor[0]=1, estado=01 at 6th edge; not earlier.
//  2. ch0: 5x150, 1x200, 5x150 -> never alarms; cont_bajo back to 0 after the 200 sample.
//  3. ch1 in CALOR (6x300), then 200 -> estado 00, alerta 0 next edge (no HIST); with HIST: 255 holds CALOR, 249 exits.
//  4. ch0 in FRIO, then single 300 -> estado 10, ventilador=1, calefactor=0 at that edge.
//  5. 3x150 valid, 4 idle cycles, 3x150 valid -> FRIO at 6th valid sample; idle cycles hold.
//  6. ch2 and ch3 alarming -> alerta_global=1, canal_alerta=2; arst_n low one edge -> all outputs 0, estado 00.
//  - Assertions throughout: mutual exclusion, reset values, no unreachable state.

Source files
------------

// File: rtl/monitoreo_pkg.sv
// Shared types for the multi-channel temperature monitor.
//   estado_t : per-channel alarm state, encoded as it appears on estado_actual
//   clase_t  : classification of a single sample against the channel thresholds
package monitoreo_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    FRIO   = 2'b01,
    CALOR  = 2'b10
  } estado_t;

  typedef enum logic [1:0] {
    BAJO,
    RANGO,
    ALTO
  } clase_t;

endpackage

// File: rtl/monitoreo_canal.sv
// Single temperature channel: classifies each valid sample, counts consecutive
// cold/hot samples and raises the alarm once PERSIST of them have been seen.
// Build option: MON_HISTERESIS_EN adds a hysteresis band on the way back to NORMAL.
// Ports:
//   clk, arst_n   clock and synchronous active-low reset
//   temp_valido   temp carries a new sample this cycle
//   temp          signed sample, tenths of a degree
//   estado        current state (00 NORMAL, 01 FRIO, 10 CALOR)
//   alerta        FRIO or CALOR
//   calefactor    FRIO
//   ventilador    CALOR
module monitoreo_canal #(
  parameter int unsigned W_TEMP  = 11,
  parameter int          T_BAJO  = 180,
  parameter int          T_ALTO  = 259,
  parameter int unsigned PERSIST = 6,
  parameter int          HIST    = 10
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     temp_valido,
  input  logic signed [W_TEMP-1:0] temp,
  output logic [1:0]               estado,
  output logic                     alerta,
  output logic                     calefactor,
  output logic                     ventilador
);
  import monitoreo_pkg::*;

  localparam int unsigned CW = $clog2(PERSIST + 1);
  localparam logic signed [W_TEMP-1:0] LimBajo = W_TEMP'(T_BAJO);
  localparam logic signed [W_TEMP-1:0] LimAlto = W_TEMP'(T_ALTO);

  estado_t         estado_q, estado_d;
  logic [CW-1:0]   cont_bajo_q, cont_bajo_d;
  logic [CW-1:0]   cont_alto_q, cont_alto_d;
  logic [CW-1:0]   bajo_inc, alto_inc;
  clase_t          clase;
  logic            sale_frio, sale_calor;

  always_comb begin
    if (temp < LimBajo) begin
      clase = BAJO;
    end else if (temp > LimAlto) begin
      clase = ALTO;
    end else begin
      clase = RANGO;
    end
  end

`ifdef MON_HISTERESIS_EN
  localparam logic signed [W_TEMP-1:0] LimSalidaFrio  = W_TEMP'(T_BAJO + HIST);
  localparam logic signed [W_TEMP-1:0] LimSalidaCalor = W_TEMP'(T_ALTO - HIST);
  // Opposite-extreme samples are handled before these, so only the band edge matters.
  assign sale_frio  = (temp >= LimSalidaFrio);
  assign sale_calor = (temp <= LimSalidaCalor);
`else
  // HIST has no effect without the hysteresis band.
  logic unused_hist;
  assign unused_hist = ^HIST;
  assign sale_frio   = (clase == RANGO);
  assign sale_calor  = (clase == RANGO);
`endif

  // Saturating increments; entering an alarm clears the counter before it can saturate.
  assign bajo_inc = (cont_bajo_q == CW'(PERSIST)) ? cont_bajo_q : cont_bajo_q + CW'(1);
  assign alto_inc = (cont_alto_q == CW'(PERSIST)) ? cont_alto_q : cont_alto_q + CW'(1);

  always_comb begin
    estado_d    = estado_q;
    cont_bajo_d = cont_bajo_q;
    cont_alto_d = cont_alto_q;
    if (temp_valido) begin
      case (estado_q)
        NORMAL: begin
          unique case (clase)
            BAJO: begin
              cont_alto_d = '0;
              if (bajo_inc == CW'(PERSIST)) begin
                estado_d    = FRIO;
                cont_bajo_d = '0;
              end else begin
                cont_bajo_d = bajo_inc;
              end
            end
            ALTO: begin
              cont_bajo_d = '0;
              if (alto_inc == CW'(PERSIST)) begin
                estado_d    = CALOR;
                cont_alto_d = '0;
              end else begin
                cont_alto_d = alto_inc;
              end
            end
            default: begin
              cont_bajo_d = '0;
              cont_alto_d = '0;
            end
          endcase
        end
        FRIO: begin
          cont_bajo_d = '0;
          cont_alto_d = '0;
          if (clase == ALTO) begin
            estado_d = CALOR;
          end else if (clase == RANGO && sale_frio) begin
            estado_d = NORMAL;
          end
        end
        CALOR: begin
          cont_bajo_d = '0;
          cont_alto_d = '0;
          if (clase == BAJO) begin
            estado_d = FRIO;
          end else if (clase == RANGO && sale_calor) begin
            estado_d = NORMAL;
          end
        end
        default: begin
          estado_d    = NORMAL;
          cont_bajo_d = '0;
          cont_alto_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      estado_q    <= NORMAL;
      cont_bajo_q <= '0;
      cont_alto_q <= '0;
    end else begin
      estado_q    <= estado_d;
      cont_bajo_q <= cont_bajo_d;
      cont_alto_q <= cont_alto_d;
    end
  end

  assign estado     = estado_q;
  assign alerta     = (estado_q != NORMAL);
  assign calefactor = (estado_q == FRIO);
  assign ventilador = (estado_q == CALOR);

endmodule

// File: rtl/monitoreo_multicanal.sv
// N-channel temperature monitor: independent per-channel monitors plus a
// global alert and the index of the lowest-numbered alarming channel.
// Build option: MON_HISTERESIS_EN (passed through to every channel).
// Ports:
//   clk, arst_n    clock and synchronous active-low reset
//   temp_valido    temp_entrada holds a new sample for every channel
//   temp_entrada   packed signed samples, channel i at [i*W_TEMP +: W_TEMP]
//   estado_actual  per-channel state, channel i at [2*i +: 2]
//   alerta         per-channel alarm
//   calefactor     per-channel heater (FRIO)
//   ventilador     per-channel fan (CALOR)
//   alerta_global  any channel alarming
//   canal_alerta   lowest alarming channel index, 0 when none
module monitoreo_multicanal #(
  parameter int unsigned N_CANALES = 4,
  parameter int unsigned W_TEMP    = 11,
  parameter int          T_BAJO    = 180,
  parameter int          T_ALTO    = 259,
  parameter int unsigned PERSIST   = 6,
  parameter int          HIST      = 10
) (
  input  logic                                                  clk,
  input  logic                                                  arst_n,
  input  logic                                                  temp_valido,
  input  logic [N_CANALES*W_TEMP-1:0]                           temp_entrada,
  output logic [2*N_CANALES-1:0]                                estado_actual,
  output logic [N_CANALES-1:0]                                  alerta,
  output logic [N_CANALES-1:0]                                  calefactor,
  output logic [N_CANALES-1:0]                                  ventilador,
  output logic                                                  alerta_global,
  output logic [((N_CANALES > 1) ? $clog2(N_CANALES) : 1)-1:0]  canal_alerta
);

  localparam int unsigned CanalW = (N_CANALES > 1) ? $clog2(N_CANALES) : 1;

  for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
    monitoreo_canal #(
      .W_TEMP  (W_TEMP),
      .T_BAJO  (T_BAJO),
      .T_ALTO  (T_ALTO),
      .PERSIST (PERSIST),
      .HIST    (HIST)
    ) u_canal (
      .clk         (clk),
      .arst_n      (arst_n),
      .temp_valido (temp_valido),
      .temp        ($signed(temp_entrada[i*W_TEMP +: W_TEMP])),
      .estado      (estado_actual[2*i +: 2]),
      .alerta      (alerta[i]),
      .calefactor  (calefactor[i]),
      .ventilador  (ventilador[i])
    );
  end

  assign alerta_global = |alerta;

  // Scan downwards so the lowest alarming index is the last one written.
  always_comb begin
    canal_alerta = '0;
    for (int i = N_CANALES - 1; i >= 0; i--) begin
      if (alerta[i]) begin
        canal_alerta = CanalW'(i);
      end
    end
  end

endmodule

// File: tb/tb_monitoreo_multicanal.sv
module tb_monitoreo_multicanal;

  localparam int N = 4;
  localparam int W = 11;

  logic                clk;
  logic                arst_n;
  logic                temp_valido;
  logic [N*W-1:0]      temp_entrada;
  logic [2*N-1:0]      estado_actual;
  logic [N-1:0]        alerta;
  logic [N-1:0]        calefactor;
  logic [N-1:0]        ventilador;
  logic                alerta_global;
  logic [1:0]          canal_alerta;

  logic signed [W-1:0] t [N];
  int                  checks   = 0;
  int                  failures = 0;
  logic                inv_on   = 1'b0;

  assign temp_entrada = {t[3], t[2], t[1], t[0]};

  monitoreo_multicanal dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .temp_valido   (temp_valido),
    .temp_entrada  (temp_entrada),
    .estado_actual (estado_actual),
    .alerta        (alerta),
    .calefactor    (calefactor),
    .ventilador    (ventilador),
    .alerta_global (alerta_global),
    .canal_alerta  (canal_alerta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply n clock edges with the current samples; outputs sampled 1 time unit after the edge.
  task automatic paso(input logic v, input int n);
    for (int k = 0; k < n; k++) begin
      temp_valido = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_todo(input string tag, input logic [7:0] est);
    logic [3:0] cal, ven, al;
    logic [1:0] idx;
    for (int i = 0; i < N; i++) begin
      cal[i] = (est[2*i +: 2] == 2'b01);
      ven[i] = (est[2*i +: 2] == 2'b10);
    end
    al  = cal | ven;
    idx = al[0] ? 2'd0 : al[1] ? 2'd1 : al[2] ? 2'd2 : al[3] ? 2'd3 : 2'd0;
    chk({tag, " estado"}, 32'(estado_actual), 32'(est));
    chk({tag, " alerta"}, 32'(alerta), 32'(al));
    chk({tag, " calefactor"}, 32'(calefactor), 32'(cal));
    chk({tag, " ventilador"}, 32'(ventilador), 32'(ven));
    chk({tag, " global"}, 32'(alerta_global), 32'(|al));
    chk({tag, " canal"}, 32'(canal_alerta), 32'(idx));
  endtask

  // Per-cycle invariants once the outputs are defined.
  always @(negedge clk) begin
    if (inv_on) begin
      chk("inv_exclusion", 32'(calefactor & ventilador), 32'd0);
      chk("inv_alerta", 32'(alerta), 32'(calefactor | ventilador));
      for (int i = 0; i < N; i++) begin
        chk("inv_estado11", 32'(estado_actual[2*i +: 2] == 2'b11), 32'd0);
      end
    end
  end

  initial begin
    arst_n      = 1'b0;
    temp_valido = 1'b0;
    for (int i = 0; i < N; i++) t[i] = 11'sd220;
    paso(1'b1, 2);
    inv_on = 1'b1;
    chk_todo("reset", 8'h00);
    arst_n = 1'b1;

    // Cold persistence: alarm exactly at the 6th sample.
    t[0] = 11'sd150;
    paso(1'b1, 5);
    chk_todo("frio_5", 8'h00);
    paso(1'b1, 1);
    chk_todo("frio_6", 8'h01);

    // FRIO straight to CALOR on one hot sample.
    t[0] = 11'sd300;
    paso(1'b1, 1);
    chk_todo("frio_a_calor", 8'h02);
    t[0] = 11'sd220;
    paso(1'b1, 1);
    chk_todo("calor_a_normal", 8'h00);

    // In-band sample restarts the cold count.
    t[0] = 11'sd150; paso(1'b1, 5);
    t[0] = 11'sd200; paso(1'b1, 1);
    t[0] = 11'sd150; paso(1'b1, 5);
    chk_todo("corte_5", 8'h00);
    paso(1'b1, 1);
    chk_todo("corte_6", 8'h01);
    t[0] = 11'sd220; paso(1'b1, 1);
    chk_todo("corte_salida", 8'h00);

    // Invalid cycles (even with an in-band sample present) do not break persistence.
    t[0] = 11'sd150; paso(1'b1, 3);
    t[0] = 11'sd220; paso(1'b0, 4);
    chk_todo("hueco", 8'h00);
    t[0] = 11'sd150; paso(1'b1, 2);
    chk_todo("hueco_5", 8'h00);
    paso(1'b1, 1);
    chk_todo("hueco_6", 8'h01);
    t[0] = 11'sd220; paso(1'b1, 1);

    // Channel 1 hot, exit behaviour.
    t[1] = 11'sd300; paso(1'b1, 6);
    chk_todo("calor_ch1", 8'h08);
    t[1] = 11'sd200; paso(1'b0, 2);
    chk_todo("calor_hold_invalido", 8'h08);
`ifdef MON_HISTERESIS_EN
    t[1] = 11'sd255; paso(1'b1, 1);
    chk_todo("hist_mantiene", 8'h08);
    t[1] = 11'sd249; paso(1'b1, 1);
    chk_todo("hist_sale", 8'h00);
`else
    paso(1'b1, 1);
    chk_todo("calor_sale", 8'h00);
`endif

    // Threshold values themselves are in-band; one step beyond alarms.
    t[0] = 11'sd180; t[1] = 11'sd259; paso(1'b1, 6);
    chk_todo("umbral_en_banda", 8'h00);
    t[0] = 11'sd179; t[1] = 11'sd260; paso(1'b1, 6);
    chk_todo("umbral_fuera", 8'h09);

    // Negative sample on ch2 (signed compare) and hot ch3.
    t[2] = -11'sd5; t[3] = 11'sd300; paso(1'b1, 6);
    chk_todo("cuatro_canales", 8'h99);
    t[0] = 11'sd220; t[1] = 11'sd220; paso(1'b1, 1);
    chk_todo("ch2_ch3", 8'h90);

    // Reset mid-alarm.
    arst_n = 1'b0; paso(1'b1, 1);
    chk_todo("reset_alarma", 8'h00);
    arst_n = 1'b1;
    for (int i = 0; i < N; i++) t[i] = 11'sd220;
    paso(1'b1, 1);
    chk_todo("post_reset", 8'h00);

    inv_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
